mem_store_ctrlr: RTL and testbench
==================================

Name: mem_store_ctrlr

Overview:
- Store-side data path between the EX/MEM stage and the word-wide data memory.
- Counterpart of the register-file write-data (load) selection.
- Word stores pass straight through to memory, registered.
- Byte stores use a read-modify-write sequence on the word-only memory, and the pipeline is stalled until the merged word is written.

Parameters:
- MEM_RD_LATENCY, 1: cycles from w_mem_re_out high to valid w_mem_rdata; legal range 1..7.
- ADDR_W, 32: byte-address width.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- w_store_op  in  1  store request from MEM stage; sampled only when not stalled
- w_byte_op  in  1  with w_store_op: byte store (sb); otherwise word store (sw)
- w_addr  in  ADDR_W  byte address of the store
- w_rt_data  in  32  store data (rt register value)
- w_mem_rdata  in  32  data-memory read data
- w_mem_addr_out  out  ADDR_W  word-aligned memory address, addr[1:0] = 0
- w_mem_wdata_out  out  32  memory write data
- w_mem_we_out  out  1  memory write enable, 1-cycle pulse
- w_mem_re_out  out  1  memory read enable, 1-cycle pulse
- w_stall_out  out  1  hold the pipeline (combinational)
- w_misalign_out  out  1  1-cycle pulse: misaligned word store dropped

Behaviour:
- Reset:
  - All outputs 0; state IDLE; latency counter 0.
  - Reset mid-sequence aborts the sequence; no write is ever issued for it.
- States: IDLE, RD, WAIT, WRITE.
- Accept condition: state IDLE and w_store_op = 1. On accept, latch w_addr and w_rt_data.
- Word store accepted in cycle N:
  - Cycle N+1: we = 1, addr = {a[ADDR_W-1:2], 2'b00}, wdata = rt_data.
  - State stays IDLE and w_stall_out stays 0, so back-to-back word stores are allowed.
- Misaligned word store (a[1:0] != 0):
  - No write.
  - w_misalign_out = 1 in cycle N+1.
- Byte store accepted in cycle N:
  - w_stall_out = 1 combinationally in cycle N.
  - Next state RD.
- RD:
  - re = 1, addr = word address.
  - Counter loaded with MEM_RD_LATENCY.
  - Next state WAIT.
- WAIT:
  - Counter decrements each cycle.
  - When the counter reaches 1: capture w_mem_rdata with the selected byte lane replaced by rt_data[7:0], into the write-data register.
  - Next state WRITE.
- Byte lanes, big-endian: a[1:0] = 0 selects bits [31:24], 1 → [23:16], 2 → [15:8], 3 → [7:0].
- WRITE:
  - we = 1 with the merged word; w_stall_out = 0.
  - Next state IDLE.
  - w_store_op is not accepted in WRITE; the next request is accepted the following cycle.
- Stall and latency:
  - w_stall_out = 1 in the accept cycle and in RD and WAIT.
  - With MEM_RD_LATENCY = 1: stall lasts cycles N..N+2 and the write occurs at N+3.
- Simultaneous events:
  - A word-store write pulse in the same cycle as a byte-store accept is legal; the RD read follows one cycle later.
  - Requests while stalled are ignored; the pipeline holds them stable.
- re and we are never high in the same cycle.
- Non-store cycles: re, we and misalign are 0; addr and wdata hold their last values.

Optional Feature:
- Macro: STORE_HALF_EN.
- When defined:
  - Adds input w_half_op (1 bit) and enables halfword stores (sh).
  - sh uses the same read-modify-write sequence.
  - a[1] = 0 replaces [31:16]; a[1] = 1 replaces [15:0], with rt_data[15:0].
  - a[0] = 1 is misaligned: w_misalign_out pulses and no memory access occurs.
  - w_byte_op has priority over w_half_op.
- When undefined:
  - Port absent.
  - Only byte and word stores exist.

Decomposition:
- Shared package pipeline_pkg holds:
  - state encoding constants: IDLE = 2'd0, RD = 2'd1, WAIT = 2'd2, WRITE = 2'd3;
  - byte-lane index constants;
  - WORD_W = 32.
- One sub-module, store_lane_merge: combinational merge of a read word, store data, address low bits and size into the write word.
- Reuse store_lane_merge in the bench as the reference model.

Test Plan:
- sw aligned: w_store_op = 1, w_byte_op = 0, addr = 0x0000_0010, rt = 0xDEAD_BEEF → cycle N+1: we = 1, addr = 0x10, wdata = 0xDEADBEEF; stall never high.
- sb lane 2: memory word 0x1122_3344 at 0x20, addr = 0x22, rt = 0x0000_00AB, latency 1 → re at N+1 (addr = 0x20); stall high N..N+2; we at N+3, wdata = 0x1122_AB44.
- sb lane 0 with MEM_RD_LATENCY = 3: word 0xFFFF_FFFF, addr = 0x4, rt = 0x12 → we at N+5, wdata = 0x12FF_FFFF; stall high N..N+4.
- Misaligned sw: addr = 0x13 → misalign = 1 at N+1; we and re stay 0.
- Back-to-back: sw 0x100 at N, then sb at N+1 → we at N+1 for the sw; re at N+2; one write per store, no overlap of re and we.
- reset asserted during WAIT → next cycle state IDLE, all outputs 0, no we; a new sw afterwards completes normally.

Source files
------------

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared FSM, access-size and byte-lane encodings for the store path
package pipeline_pkg;
  localparam int WORD_W = 32;
  localparam logic [1:0] LANE_MSB = 2'd0;
  localparam logic [1:0] LANE_LSB = 2'd3;
  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WAIT = 2'd2, WRITE = 2'd3} state_t;
  typedef enum logic [1:0] {SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2} size_t;
  function automatic logic misaligned(size_t sz, logic [1:0] lo);
    return sz == SZ_WORD ? |lo : sz == SZ_HALF ? lo[0] : 1'b0;
  endfunction
endpackage

// File: rtl/store_lane_merge.sv
// store_lane_merge: big-endian merge of store data into a read word by size and address low bits
module store_lane_merge
  import pipeline_pkg::*;
(
  input  logic [WORD_W-1:0] i_rdata,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic [1:0]        i_lo,
  input  size_t             i_size,
  output logic [WORD_W-1:0] o_word
);
  logic [4:0]        w_sh;
  logic [WORD_W-1:0] w_mask;
  always_comb begin
    w_sh = i_size == SZ_WORD ? 5'd0 :
           i_size == SZ_HALF ? {i_lo[1] == LANE_MSB[1], 4'd0} : {2'(LANE_LSB - i_lo), 3'd0};
    w_mask = (i_size == SZ_WORD ? 32'hFFFF_FFFF : i_size == SZ_HALF ? 32'h0000_FFFF : 32'h0000_00FF) << w_sh;
    o_word = (i_rdata & ~w_mask) | ((i_wdata << w_sh) & w_mask);
  end
endmodule

// File: rtl/mem_store_ctrlr.sv
// mem_store_ctrlr: store path to word-only data memory; byte stores use read-modify-write.
// STORE_HALF_EN adds w_half_op and halfword stores through the same sequence.
module mem_store_ctrlr
  import pipeline_pkg::*;
#(
  parameter int MEM_RD_LATENCY = 1,
  parameter int ADDR_W         = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              w_store_op,
  input  logic              w_byte_op,
`ifdef STORE_HALF_EN
  input  logic              w_half_op,
`endif
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [WORD_W-1:0] w_rt_data,
  input  logic [WORD_W-1:0] w_mem_rdata,
  output logic [ADDR_W-1:0] w_mem_addr_out,
  output logic [WORD_W-1:0] w_mem_wdata_out,
  output logic              w_mem_we_out,
  output logic              w_mem_re_out,
  output logic              w_stall_out,
  output logic              w_misalign_out
);
  state_t            r_state, w_next;
  size_t             w_size, r_size;
  logic              w_acc, w_mis, w_sw, w_rmw;
  logic [1:0]        r_lo;
  logic [2:0]        r_cnt;
  logic [WORD_W-1:0] r_data, r_wdata, w_merged;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we, r_re, r_mis;
  always_comb begin
`ifdef STORE_HALF_EN
    w_size = w_byte_op ? SZ_BYTE : w_half_op ? SZ_HALF : SZ_WORD;
`else
    w_size = w_byte_op ? SZ_BYTE : SZ_WORD;
`endif
    w_acc = r_state == IDLE && w_store_op;
    w_mis = w_acc && misaligned(w_size, w_addr[1:0]);
    w_sw = w_acc && !w_mis && w_size == SZ_WORD;
    w_rmw = w_acc && !w_mis && w_size != SZ_WORD;
    w_stall_out = w_rmw || r_state == RD || r_state == WAIT;
    w_next = r_state == IDLE ? (w_rmw ? RD : IDLE) :
             r_state == RD   ? WAIT :
             r_state == WAIT ? (r_cnt == 3'd1 ? WRITE : WAIT) : IDLE;
  end
  always_ff @(posedge clock)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  store_lane_merge u_merge (
    .i_rdata(w_mem_rdata),
    .i_wdata(r_data),
    .i_lo   (r_lo),
    .i_size (r_size),
    .o_word (w_merged)
  );
  // Output strobes are registered one cycle behind the state that requests them.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_lo <= '0;
      r_size <= SZ_BYTE;
      r_data <= '0;
      r_wdata <= '0;
      r_addr <= '0;
      r_cnt <= '0;
      r_we <= 1'b0;
      r_re <= 1'b0;
      r_mis <= 1'b0;
    end else begin
      r_we <= w_sw;
      r_re <= w_rmw;
      r_mis <= w_mis;
      if (w_acc) begin
        r_lo <= w_addr[1:0];
        r_size <= w_size;
        r_data <= w_rt_data;
      end
      if (w_sw || w_rmw) r_addr <= {w_addr[ADDR_W-1:2], 2'b00};
      if (w_sw) r_wdata <= w_rt_data;
      if (r_state == RD) r_cnt <= 3'(MEM_RD_LATENCY);
      if (r_state == WAIT) begin
        r_cnt <= r_cnt - 3'd1;
        if (r_cnt == 3'd1) begin
          r_wdata <= w_merged;
          r_we <= 1'b1;
        end
      end
    end
  end
  assign w_mem_addr_out = r_addr;
  assign w_mem_wdata_out = r_wdata;
  assign w_mem_we_out = r_we;
  assign w_mem_re_out = r_re;
  assign w_misalign_out = r_mis;
endmodule

// File: tb/tb_mem_store_ctrlr.sv
// tb_mem_store_ctrlr: directed checks of word, byte (RMW) and misaligned stores at read latencies 1 and 3
module tb_mem_store_ctrlr;
  import pipeline_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic        store, byte_op;
`ifdef STORE_HALF_EN
  logic        half_op;
`endif
  logic [31:0] addr, rt;
  logic [31:0] rd1, rd3, a1, a3, wd1, wd3;
  logic        we1, we3, re1, re3, st1, st3, mis1, mis3;
  logic [31:0] ref_rd, ref_wd, ref_out;
  logic [1:0]  ref_lo;
  size_t       ref_sz;
  int n_vec = 0;
  int n_err = 0;
  int wcnt;

  mem_store_ctrlr #(.MEM_RD_LATENCY(1), .ADDR_W(32)) d1 (
    .clock(clk), .reset(rst), .w_store_op(store), .w_byte_op(byte_op),
`ifdef STORE_HALF_EN
    .w_half_op(half_op),
`endif
    .w_addr(addr), .w_rt_data(rt), .w_mem_rdata(rd1),
    .w_mem_addr_out(a1), .w_mem_wdata_out(wd1), .w_mem_we_out(we1),
    .w_mem_re_out(re1), .w_stall_out(st1), .w_misalign_out(mis1)
  );
  mem_store_ctrlr #(.MEM_RD_LATENCY(3), .ADDR_W(32)) d3 (
    .clock(clk), .reset(rst), .w_store_op(store), .w_byte_op(byte_op),
`ifdef STORE_HALF_EN
    .w_half_op(half_op),
`endif
    .w_addr(addr), .w_rt_data(rt), .w_mem_rdata(rd3),
    .w_mem_addr_out(a3), .w_mem_wdata_out(wd3), .w_mem_we_out(we3),
    .w_mem_re_out(re3), .w_stall_out(st3), .w_misalign_out(mis3)
  );
  store_lane_merge u_ref (.i_rdata(ref_rd), .i_wdata(ref_wd), .i_lo(ref_lo), .i_size(ref_sz), .o_word(ref_out));

  logic [31:0] mem1 [256];
  logic [31:0] mem3 [256];
  logic [31:0] p1, p3a, p3b, p3c;
  always @(posedge clk) begin
    if (we1) mem1[a1[9:2]] <= wd1;
    if (we3) mem3[a3[9:2]] <= wd3;
    p1 <= re1 ? mem1[a1[9:2]] : 32'h0BAD_0BAD;
    p3a <= re3 ? mem3[a3[9:2]] : 32'h0BAD_0BAD;
    p3b <= p3a;
    p3c <= p3b;
  end
  assign rd1 = p1;
  assign rd3 = p3c;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    store = 0; byte_op = 0; addr = 0; rt = 0;
`ifdef STORE_HALF_EN
    half_op = 0;
`endif
    ref_rd = 0; ref_wd = 0; ref_lo = 0; ref_sz = SZ_BYTE;
    for (int i = 0; i < 256; i++) begin
      mem1[i] = 0;
      mem3[i] = 0;
    end
    mem1[8] = 32'h1122_3344;
    mem1[1] = 32'hFFFF_FFFF;
    mem3[1] = 32'hFFFF_FFFF;
    tick; tick;
    chk("rst_we", we1, 0);
    chk("rst_re", re1, 0);
    chk("rst_stall", st1, 0);
    chk("rst_mis", mis1, 0);
    chk("rst_addr", a1, 0);
    chk("rst_wdata", wd1, 0);
    rst = 0;
    tick;
    // aligned word store
    store = 1; addr = 32'h10; rt = 32'hDEAD_BEEF; #1;
    chk("sw_stall_n", st1, 0);
    tick; store = 0; #1;
    chk("sw_we", we1, 1);
    chk("sw_addr", a1, 32'h10);
    chk("sw_wdata", wd1, 32'hDEAD_BEEF);
    chk("sw_stall_n1", st1, 0);
    chk("sw_re", re1, 0);
    tick;
    chk("sw_we_pulse", we1, 0);
    // byte store, lane 2, latency 1
    store = 1; byte_op = 1; addr = 32'h22; rt = 32'hAB; #1;
    chk("sb2_stall_n", st1, 1);
    tick; store = 0; byte_op = 0; #1;
    chk("sb2_re", re1, 1);
    chk("sb2_raddr", a1, 32'h20);
    chk("sb2_stall_n1", st1, 1);
    chk("sb2_we_n1", we1, 0);
    tick;
    chk("sb2_stall_n2", st1, 1);
    chk("sb2_re_n2", re1, 0);
    chk("sb2_we_n2", we1, 0);
    ref_rd = 32'h1122_3344; ref_wd = 32'hAB; ref_lo = 2'd2; ref_sz = SZ_BYTE;
    tick;
    chk("sb2_we", we1, 1);
    chk("sb2_wdata_ref", wd1, ref_out);
    chk("sb2_wdata", wd1, 32'h1122_AB44);
    chk("sb2_stall_n3", st1, 0);
    chk("sb2_re_n3", re1, 0);
    tick;
    chk("sb2_we_pulse", we1, 0);
    repeat (3) tick;
    // byte store, lane 0, latency 3
    store = 1; byte_op = 1; addr = 32'h4; rt = 32'h12; #1;
    chk("sb0_stall_n", st3, 1);
    tick; store = 0; byte_op = 0; #1;
    chk("sb0_re", re3, 1);
    chk("sb0_raddr", a3, 32'h4);
    tick;
    chk("sb0_stall_n2", st3, 1);
    tick;
    chk("sb0_stall_n3", st3, 1);
    chk("sb0_we_n3", we3, 0);
    chk("sb0_l1_we_n3", we1, 1);
    chk("sb0_l1_wdata", wd1, 32'h12FF_FFFF);
    tick;
    chk("sb0_stall_n4", st3, 1);
    chk("sb0_we_n4", we3, 0);
    ref_rd = 32'hFFFF_FFFF; ref_wd = 32'h12; ref_lo = 2'd0; ref_sz = SZ_BYTE;
    tick;
    chk("sb0_we", we3, 1);
    chk("sb0_wdata", wd3, 32'h12FF_FFFF);
    chk("sb0_wdata_ref", wd3, ref_out);
    chk("sb0_stall_n5", st3, 0);
    tick;
    // misaligned word store
    store = 1; addr = 32'h13; rt = 32'h5555_5555; #1;
    chk("mis_stall_n", st1, 0);
    tick; store = 0; #1;
    chk("mis_pulse", mis1, 1);
    chk("mis_we", we1, 0);
    chk("mis_re", re1, 0);
    chk("mis_addr_hold", a1, 32'h4);
    chk("mis_wdata_hold", wd1, 32'h12FF_FFFF);
    tick;
    chk("mis_pulse_end", mis1, 0);
    // back-to-back sw then sb
    store = 1; addr = 32'h100; rt = 32'hCAFE_F00D; #1;
    tick; byte_op = 1; addr = 32'h101; rt = 32'h5A; #1;
    chk("b2b_sw_we", we1, 1);
    chk("b2b_sw_addr", a1, 32'h100);
    chk("b2b_sw_wdata", wd1, 32'hCAFE_F00D);
    chk("b2b_sw_re", re1, 0);
    chk("b2b_sb_stall", st1, 1);
    tick; store = 0; byte_op = 0; #1;
    chk("b2b_re", re1, 1);
    chk("b2b_re_we", we1, 0);
    chk("b2b_raddr", a1, 32'h100);
    tick;
    chk("b2b_wait_stall", st1, 1);
    chk("b2b_wait_re", re1, 0);
    chk("b2b_wait_we", we1, 0);
    tick;
    chk("b2b_sb_we", we1, 1);
    chk("b2b_sb_wdata", wd1, 32'hCA5A_F00D);
    chk("b2b_sb_re", re1, 0);
    chk("b2b_sb_stall", st1, 0);
    repeat (4) tick;
    // reset in WAIT aborts the byte store
    store = 1; byte_op = 1; addr = 32'h8; rt = 32'h77; #1;
    tick; store = 0; byte_op = 0;
    tick;
    chk("rw_wait_stall", st3, 1);
    rst = 1;
    tick;
    chk("rw_stall", st3, 0);
    chk("rw_we", we3, 0);
    chk("rw_re", re3, 0);
    chk("rw_mis", mis3, 0);
    chk("rw_addr", a3, 0);
    chk("rw_wdata", wd3, 0);
    rst = 0;
    wcnt = 0;
    repeat (6) begin
      tick;
      if (we3) wcnt++;
    end
    chk("rw_no_write", wcnt, 0);
    store = 1; addr = 32'h40; rt = 32'h0102_0304; #1;
    tick; store = 0; #1;
    chk("rw_sw_we", we3, 1);
    chk("rw_sw_addr", a3, 32'h40);
    chk("rw_sw_wdata", wd3, 32'h0102_0304);
    tick;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
